// File: rtl/alu_rom_sequencer.sv
// ROM-driven program sequencer: fetches, latches and executes instructions on an internal ALU.
// Build option: define ALU_SAT_EN to saturate ADD/SUB/INC/DEC on signed overflow (default wraps).
module alu_rom_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     step,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [2*DATA_W+OP_W-1:0] rom_data,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [OP_W-1:0]          opcode,
  output logic [DATA_W-1:0]        result,
  output logic [3:0]               flags,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int ROM_W = 2*DATA_W + OP_W;
  localparam int M     = DATA_W - 1;

  // Handshake: start/step/abort are single-cycle pulses with no ready; start is only
  // honoured in IDLE, step only in PAUSE, abort in any non-IDLE state (abort beats step).
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, PAUSE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c;
  logic                alu_v;
  logic [3:0]          alu_flags;

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opcode)
      OP_W'(0): begin
        sum   = {1'b0, op_a} + {1'b0, op_b};
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = (op_a[M] == op_b[M]) && (alu_r[M] != op_a[M]);
      end
      OP_W'(1): begin
        sum   = {1'b0, op_a} - {1'b0, op_b};
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = (op_a[M] != op_b[M]) && (alu_r[M] != op_a[M]);
      end
      OP_W'(2):  alu_r = op_a & op_b;
      OP_W'(3):  alu_r = op_a | op_b;
      OP_W'(4):  alu_r = op_a ^ op_b;
      OP_W'(5):  alu_r = ~op_a;
      OP_W'(6): begin
        alu_r = {op_a[M-1:0], 1'b0};
        alu_c = op_a[M];
      end
      OP_W'(7): begin
        alu_r = {1'b0, op_a[M:1]};
        alu_c = op_a[0];
      end
      OP_W'(8):  alu_r = op_a;
      OP_W'(9):  alu_r = op_b;
      OP_W'(10): begin
        sum   = {1'b0, op_a} + (DATA_W+1)'(1);
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = !op_a[M] && alu_r[M];
      end
      OP_W'(11): begin
        sum   = {1'b0, op_a} - (DATA_W+1)'(1);
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = op_a[M] && !alu_r[M];
      end
      default: alu_r = '0;
    endcase
`ifdef ALU_SAT_EN
    // Only arithmetic ops can set V; the sign of A tells which rail was crossed.
    if (alu_v)
      alu_r = op_a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
    alu_flags = {alu_v, alu_c, alu_r[M], (alu_r == '0)};
  end

  assign busy = (state != IDLE);

  // rom_addr is loaded on entry to FETCH so the ROM word is ready for LATCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= '0;
      rom_addr     <= '0;
      op_a         <= '0;
      op_b         <= '0;
      opcode       <= '0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc       <= start_addr;
            rom_addr <= start_addr;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (abort) state <= IDLE;
          else begin
            rom_addr <= pc;
            state    <= LATCH;
          end
        end
        LATCH: begin
          if (abort) state <= IDLE;
          else begin
            op_a   <= rom_data[ROM_W-1 -: DATA_W];
            op_b   <= rom_data[ROM_W-DATA_W-1 -: DATA_W];
            opcode <= rom_data[OP_W-1:0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          result       <= alu_r;
          flags        <= alu_flags;
          result_valid <= 1'b1;
          if (abort) state <= IDLE;
          else if (pc == end_addr) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            pc <= pc + 1'b1;
            if (step_mode) state <= PAUSE;
            else begin
              rom_addr <= pc + 1'b1;
              state    <= FETCH;
            end
          end
        end
        PAUSE: begin
          if (abort) state <= IDLE;
          else if (step) begin
            rom_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_rom_sequencer.md
Name: alu_rom_sequencer

Overview:
Autonomous program sequencer for the ROM-driven ALU datapath. It walks a range of a synchronous instruction ROM, latches each word's operands and opcode, and executes them on an internal parametrised ALU. Results and flags are registered. It runs either free-running or single-stepped, and its outputs feed the 7-segment decoders and LEDs at top level.

Parameters:
DATA_W, 8, operand and result width in bits
OP_W, 4, opcode width in bits; must be at least 4
ADDR_W, 8, ROM address width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run from start_addr
step_mode  in  1  1 = pause after each instruction; sampled on each EXEC cycle
step  in  1  one-cycle pulse; advances from PAUSE
abort  in  1  one-cycle pulse; returns to IDLE
start_addr  in  ADDR_W  first instruction address
end_addr  in  ADDR_W  last instruction address, inclusive
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  2*DATA_W+OP_W  ROM word: A = [MSB -: DATA_W], B = next DATA_W bits, opcode = [OP_W-1:0]
op_a  out  DATA_W  latched operand A
op_b  out  DATA_W  latched operand B
opcode  out  OP_W  latched opcode, drives LEDs at top level
result  out  DATA_W  registered ALU result
flags  out  4  {V,C,N,Z}, registered together with result
result_valid  out  1  one-cycle pulse when result and flags update
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the end_addr instruction executes

Behaviour:
- Reset: when rst_n = 0 at a clock edge, state goes to IDLE. Every output and the internal pc go to 0. Reset overrides all other inputs, including mid-run.
- ROM timing: the ROM samples rom_addr at edge k. rom_data is valid during cycle k+1.
- States: IDLE, FETCH, LATCH, EXEC, PAUSE.
- IDLE: on start, pc <= start_addr and state goes to FETCH. All other inputs are ignored in IDLE.
- FETCH: rom_addr <= pc. Next state is LATCH.
- LATCH: op_a, op_b and opcode are loaded from rom_data. Next state is EXEC.
- EXEC: result and flags are loaded and result_valid = 1 for exactly this cycle.
  - If pc == end_addr: done = 1 for this cycle and the next state is IDLE.
  - Otherwise pc <= pc+1, wrapping modulo 2^ADDR_W. The next state is PAUSE if step_mode = 1, else FETCH.
- PAUSE: waits for step, then goes to FETCH. step in any other state is ignored.
- Throughput: 3 cycles per instruction in run mode. The first result_valid occurs 3 cycles after the start edge.
- Wrap: if end_addr < start_addr, execution runs through 2^ADDR_W-1, then 0, up to end_addr. If start_addr == end_addr, exactly one instruction executes.
- start while busy: ignored.
- abort: from any non-IDLE state, state goes to IDLE at the next edge. result, flags, op_a, op_b and opcode hold their values. An abort in EXEC still commits that result but suppresses done. abort takes priority over step.
- ALU (opcodes): 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 PASS A, 9 PASS B, 10 INC A, 11 DEC A. Any other opcode gives result = 0 and flags = 4'b0001.
- Flags:
  - Z = (result == 0).
  - N = result[DATA_W-1].
  - C = carry-out for ADD and INC; borrow (A < B unsigned) for SUB; borrow for DEC when A == 0; the shifted-out bit for SHL and SHR; 0 otherwise.
  - V = signed overflow for ADD, SUB, INC and DEC; 0 otherwise.
- Arithmetic is performed at DATA_W+1 bits. Result is truncated to DATA_W bits.

Optional Feature:
ALU_SAT_EN
- Defined: ADD, SUB, INC and DEC saturate on signed overflow. Positive overflow clamps to 2^(DATA_W-1)-1; negative overflow clamps to -2^(DATA_W-1). V is still set. C is unchanged from its wrap-mode definition. N and Z are computed from the clamped result.
- Undefined: all arithmetic wraps.

Test Plan:
- Reset: assert rst_n = 0 for 2 cycles during EXEC -> all outputs 0, busy = 0; a following start runs normally.
- Run: start_addr = 0, end_addr = 2; ROM[0] = {05,03,ADD}, ROM[1] = {03,05,SUB}, ROM[2] = {F0,3C,AND} -> results 08 (flags 0000), FE (C=1, N=1), 30 (flags 0000). result_valid pulses 3 cycles apart; done coincides with the third pulse.
- Overflow: {7F,01,ADD} -> 80 with V=1, N=1 (with ALU_SAT_EN: 7F with V=1, N=0). {80,01,SUB} -> 7F with V=1 (with ALU_SAT_EN: 80 with V=1, N=1).
- Step mode: step_mode = 1, range 4..5 -> the sequencer stops in PAUSE after the first result. No further rom_addr change until step; step issued 10 cycles later -> the second result_valid occurs 3 cycles after it.
- Wrap: start_addr = FF, end_addr = 01 -> rom_addr sequence FF, 00, 01; three result_valid pulses, then done.
- Abort/illegal: abort during the second FETCH of a 4-instruction run -> IDLE next cycle with no done and the first result held. start while busy has no effect. Opcode 0xE -> result 00, flags 0001.
